// File: rtl/md_pkg.sv
// Shared definitions for the E-stage multiply/divide unit: operation codes,
// the computed-result record and the long-operation predicate.
package md_pkg;

  localparam logic [2:0] MD_NONE  = 3'd0;
  localparam logic [2:0] MD_MULT  = 3'd1;
  localparam logic [2:0] MD_MULTU = 3'd2;
  localparam logic [2:0] MD_DIV   = 3'd3;
  localparam logic [2:0] MD_DIVU  = 3'd4;
  localparam logic [2:0] MD_MTHI  = 3'd5;
  localparam logic [2:0] MD_MTLO  = 3'd6;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        wr;  // cleared for divide-by-zero so HI/LO keep their value
  } md_result_t;

  function automatic logic md_is_long(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers. The result is computed
// at issue, parked in pend_*, and committed when the latency counter expires.
module md_unit
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  mdOp,
  input  logic [31:0] dataA,
  input  logic [31:0] dataB,
  input  logic        mdUse,
  output logic        busy,
  output logic        mdStall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

  logic [3:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] pend_hi_q, pend_hi_d;
  logic [31:0] pend_lo_q, pend_lo_d;
  logic        pend_wr_q, pend_wr_d;

  md_result_t  res;
  logic [63:0] prod;

  // NOTE: every signal assigned in an always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    res  = '0;
    prod = '0;
    case (mdOp)
      MD_MULT: begin
        prod = $signed({{32{dataA[31]}}, dataA}) * $signed({{32{dataB[31]}}, dataB});
        res  = '{hi: prod[63:32], lo: prod[31:0], wr: 1'b1};
      end
      MD_MULTU: begin
        prod = {32'd0, dataA} * {32'd0, dataB};
        res  = '{hi: prod[63:32], lo: prod[31:0], wr: 1'b1};
      end
      MD_DIV: begin
        if (dataB == 32'd0) begin
          res.wr = 1'b0;
        end else if (dataA == 32'h8000_0000 && dataB == 32'hFFFF_FFFF) begin
          // The only signed quotient that overflows; pin it to the wrapped value.
          res = '{hi: 32'd0, lo: 32'h8000_0000, wr: 1'b1};
        end else begin
          res.lo = 32'($signed(dataA) / $signed(dataB));
          res.hi = 32'($signed(dataA) % $signed(dataB));
          res.wr = 1'b1;
        end
      end
      MD_DIVU: begin
        if (dataB != 32'd0) begin
          res = '{hi: dataA % dataB, lo: dataA / dataB, wr: 1'b1};
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_wr_d = pend_wr_q;

    if (cnt_q == 4'd0) begin
      if (start) begin
        case (mdOp)
          MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
            pend_hi_d = res.hi;
            pend_lo_d = res.lo;
            pend_wr_d = res.wr;
            cnt_d     = (mdOp == MD_DIV || mdOp == MD_DIVU) ? DIV_N : MULT_N;
          end
          MD_MTHI: hi_d = dataA;
          MD_MTLO: lo_d = dataA;
          default: ;
        endcase
      end
    end else begin
      // Issue attempts while running fall through here and are dropped.
      cnt_d = cnt_q - 4'd1;
      if (cnt_q == 4'd1 && pend_wr_q) begin
        hi_d = pend_hi_q;
        lo_d = pend_lo_q;
      end
    end

    busy_d = (cnt_d != 4'd0);
  end

  // NOTE: sequential state uses non-blocking assignments only, and the reset
  // here is synchronous: it is just the highest-priority branch at the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= 4'd0;
      busy_q    <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
      pend_wr_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_wr_q <= pend_wr_d;
    end
  end

  assign busy    = busy_q;
  assign hi      = hi_q;
  assign lo      = lo_q;
  assign mdStall = mdUse & (busy_q | (start & md_is_long(mdOp)));

endmodule

// File: doc/md_unit.md
# md_unit

Multi-cycle multiply/divide unit with HI/LO registers for the P6 pipelined MIPS core, sitting in the E stage beside the ALU. It accepts mult/multu/div/divu/mthi/mtlo from the E stage, holds the pipeline off via a stall request while an operation is in flight, and commits results to HI/LO after a fixed, op-dependent latency. mfhi/mflo read the registered `hi`/`lo` outputs.

## Interface
- `MULT_CYCLES`, default 5: busy duration for mult/multu, legal range 1..15.
- `DIV_CYCLES`, default 10: busy duration for div/divu, legal range 1..15.

Ports:
- `clk`  in  1: clock. One clock domain.
- `reset`  in  1: synchronous, active-high reset.
- `start`  in  1: E-stage instruction issues `mdOp` this cycle.
- `mdOp`  in  3: operation code (encodings in `md_pkg`).
- `dataA`  in  32: rs operand, forwarded value.
- `dataB`  in  32: rt operand, forwarded value.
- `mdUse`  in  1: D-stage instruction uses the MDU (mult/div/mf*/mt*).
- `busy`  out  1: operation in flight.
- `mdStall`  out  1: stall request to hazard unit.
- `hi`  out  32: HI register.
- `lo`  out  32: LO register.

## Operation
- Reset: `hi`=0, `lo`=0, `busy`=0, counter=0, pending results=0. Reset mid-operation discards the pending result; HI/LO are not written.
- States: IDLE (counter=0) and RUN (counter≠0). `busy` = (counter≠0), registered.
- IDLE, `start` with MULT/MULTU/DIV/DIVU: compute the result from `dataA`/`dataB` the same cycle, latch it into pendHi/pendLo, load the counter with MULT_CYCLES or DIV_CYCLES, and go to RUN.
- RUN: decrement the counter each cycle. On the edge where the counter goes 1→0, `hi`<=pendHi and `lo`<=pendLo, and the unit returns to IDLE.
- MTHI/MTLO in IDLE: write `hi`/`lo`=`dataA` at the next edge. The counter is not touched.
- Any `start` while `busy`=1 is ignored. The hazard unit guarantees this does not occur, and verification checks that HI/LO and the counter are unaffected. MD_NONE, or `start`=0, is a no-op.
- Arithmetic:
  - MULT: signed 32×32→64. MULTU: unsigned.
  - HI = product[63:32], LO = product[31:0].
  - DIV: LO = quotient truncated toward zero, HI = remainder with the sign of the dividend. DIVU: unsigned.
  - Division by zero: busy for DIV_CYCLES, then HI/LO are left unchanged.
  - DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- `mdStall` = `mdUse` & (`busy` | (`start` & mdOp ∈ {MULT, MULTU, DIV, DIVU})). This is combinational.

## Timing
- `start` at cycle t (edge t+1 latches) → `busy`=1 for cycles t+1 … t+N, where N is the op latency. New HI/LO are visible in cycle t+N+1, the same cycle `busy` falls.
- MTHI/MTLO at cycle t → new value visible in cycle t+1. `busy` stays 0.
- A back-to-back `start` in cycle t+N+1 is accepted (no dead cycle).
- `mdStall` asserts in cycle t itself when a D-stage MDU instruction follows a mult/div issue, and deasserts in cycle t+N+1.
- `hi`/`lo` are registered. mfhi in the E stage reads them directly; no internal bypass.

## Structure
- `md_pkg`:
  - op encodings: MD_NONE=0, MD_MULT=1, MD_MULTU=2, MD_DIV=3, MD_DIVU=4, MD_MTHI=5, MD_MTLO=6; 7 is reserved and treated as MD_NONE.
  - predicate function `md_is_long(op)`.
- Single module; 4-bit down-counter plus pendHi/pendLo registers.
- Arithmetic uses behavioural `*`, `/`, `%` with `$signed`. No sub-module.

## Test plan
- Reset, then MULT 0xFFFFFFFE × 3 → `busy` high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001 after 5 cycles.
- DIV -7 / 2 → after 10 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7 / 0 → HI/LO unchanged.
- MTHI 0x12345678 → `hi`=0x12345678 next cycle, `busy` never asserted. Then DIV 0x80000000 / -1 → LO=0x80000000, HI=0.
- DIV issued with `mdUse`=1 → `mdStall` high from the issue cycle through the last busy cycle (11 cycles). A second `start` mid-run is ignored, and HI/LO are unchanged until completion.
- `reset` asserted at busy cycle 3 of a MULT → next cycle `busy`=0, HI=LO=0, and no later commit occurs.
